bitonic_sort8_pipe: RTL and testbench

Parametrised, fully pipelined 8-lane bitonic sorter: the complete 3-stage bitonic network (all six compare-exchange layers) with one register layer per compare layer. Adds configurable data width, signed/unsigned compare, a per-item ascending/descending mode, and a valid/ready handshake with backpressure. Sits between a sample-collection front end and downstream median/rank logic. Sustains one 8-element vector per cycle.

---
 rtl/bitonic_sort8_pipe.sv | 101 ++++++++++
 tb/tb_bitonic_sort8_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_sort8_pipe.sv
// Pipelined 8-lane bitonic sorter: input capture register followed by six
// registered compare-exchange layers, with a global stall for backpressure.

module bitonic_ce #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dn,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic a_gt_b, b_gt_a, swap;

  generate
    if (SIGNED != 0) begin : g_s
      assign a_gt_b = $signed(a) > $signed(b);
      assign b_gt_a = $signed(b) > $signed(a);
    end else begin : g_u
      assign a_gt_b = a > b;
      assign b_gt_a = b > a;
    end
  endgenerate

  // strict compares: equal elements never swap
  assign swap = dn ? b_gt_a : a_gt_b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

module bitonic_sort8_pipe #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*WIDTH-1:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [8*WIDTH-1:0] data_out
);
  localparam int NUM_LANES = 8;
  localparam int STAGES    = 6;

  typedef struct packed {
    logic                            mode;
    logic [NUM_LANES-1:0][WIDTH-1:0] data;
  } vec_t;

  vec_t            stg_q [STAGES+1];
  vec_t            stg_d [STAGES];
  logic [STAGES:0] vld_pipe;
  logic            stall;

  assign stall    = vld_pipe[STAGES] & ~out_ready;
  assign in_ready = ~stall;

  // Layer s reads stg_q[s] and feeds stg_q[s+1]; directions listed for
  // ascending order and flipped per vector by its mode bit.
  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_layer
      localparam int DIST = (s == 1 || s == 4) ? 2 : (s == 3) ? 4 : 1;
      assign stg_d[s].mode = stg_q[s].mode;
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        if ((l & DIST) == 0) begin : g_ce
          localparam bit DN_ASC = (s == 0) ? (((l >> 1) & 1) == 1) :
                                  (s < 3)  ? (((l >> 2) & 1) == 1) : 1'b0;
          bitonic_ce #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_ce (
            .a  (stg_q[s].data[l]),
            .b  (stg_q[s].data[l+DIST]),
            .dn (stg_q[s].mode ^ DN_ASC),
            .lo (stg_d[s].data[l]),
            .hi (stg_d[s].data[l+DIST])
          );
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i <= STAGES; i++) stg_q[i] <= '0;
    end else if (!stall) begin
      // bubbles advance like data; only the valid bit marks them
      vld_pipe      <= {vld_pipe[STAGES-1:0], in_valid};
      stg_q[0].mode <= in_mode;
      stg_q[0].data <= data_in;
      for (int i = 0; i < STAGES; i++) stg_q[i+1] <= stg_d[i];
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_mode  = stg_q[STAGES].mode;
  assign data_out  = stg_q[STAGES].data;
endmodule

// File: tb/tb_bitonic_sort8_pipe.sv
// Bench for bitonic_sort8_pipe: unsigned and signed instances share stimulus,
// outputs are compared against a plain sort of each accepted vector.
module tb_bitonic_sort8_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [63:0] data_in = '0;
  logic        in_ready, out_valid, out_mode;
  logic [63:0] data_out;
  logic        in_ready_s, out_valid_s, out_mode_s;
  logic [63:0] data_out_s;

  int total = 0, bad = 0, cyc = 0;
  logic [63:0] q_data[$];
  logic        q_mode[$];
  int          q_cyc[$];

  bitonic_sort8_pipe #(.WIDTH(8), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .data_out(data_out));

  bitonic_sort8_pipe #(.WIDTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_mode(in_mode),
    .data_in(data_in), .out_valid(out_valid_s), .out_ready(out_ready), .out_mode(out_mode_s),
    .data_out(data_out_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] lanes(input logic [7:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [63:0] sort_ref(input logic [63:0] d, input logic mode, input bit sgn);
    int v[8];
    int t;
    logic [7:0] b;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      b = d[i*8 +: 8];
      v[i] = sgn ? int'($signed(b)) : int'(b);
    end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    r = '0;
    for (int i = 0; i < 8; i++) begin
      t = mode ? v[7-i] : v[i];
      r[i*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic flush_q;
    q_data.delete(); q_mode.delete(); q_cyc.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (data_out !== 64'h0) begin bad++; $display("FAIL rst_data_out got=%h exp=0", data_out); end
    total++; if (out_mode !== 1'b0) begin bad++; $display("FAIL rst_out_mode got=%b exp=0", out_mode); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid_s !== 1'b0 || data_out_s !== 64'h0) begin
      bad++; $display("FAIL rst_signed got=%b/%h exp=0/0", out_valid_s, data_out_s);
    end
    out_ready = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [63:0] din[3], eu[3], es[3];
    logic        md[3];
    din[0] = lanes(8'd7, 8'd3, 8'd9, 8'd1, 8'd8, 8'd2, 8'd6, 8'd5); md[0] = 1'b0;
    eu[0]  = lanes(8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
    es[0]  = eu[0];
    din[1] = lanes(8'd4, 8'd4, 8'd0, 8'd255, 8'd4, 8'd17, 8'd0, 8'd255); md[1] = 1'b1;
    eu[1]  = lanes(8'd255, 8'd255, 8'd17, 8'd4, 8'd4, 8'd4, 8'd0, 8'd0);
    es[1]  = lanes(8'd17, 8'd4, 8'd4, 8'd4, 8'd0, 8'd0, 8'd255, 8'd255);
    din[2] = lanes(8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h02, 8'h81); md[2] = 1'b0;
    eu[2]  = lanes(8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF);
    es[2]  = lanes(8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = md[i]; data_in = din[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early got=%b exp=0", i, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_valid got=%b exp=1", i, out_valid); end
      total++; if (data_out !== eu[i]) begin bad++; $display("FAIL dir%0d_data got=%h exp=%h", i, data_out, eu[i]); end
      total++; if (out_mode !== md[i]) begin bad++; $display("FAIL dir%0d_mode got=%b exp=%b", i, out_mode, md[i]); end
      total++; if (data_out_s !== es[i]) begin bad++; $display("FAIL dir%0d_signed got=%h exp=%h", i, data_out_s, es[i]); end
    end
  endtask

  task automatic test_stream;
    int sent = 0, got = 0, t = 0, c;
    logic [63:0] d;
    logic m;
    flush_q();
    while (got < 20 && t < 200) begin
      @(negedge clk); t++;
      if (out_valid) begin
        total++;
        if (q_data.size() == 0) begin bad++; $display("FAIL stream_spurious got=%h exp=none", data_out); end
        else begin
          d = q_data.pop_front(); m = q_mode.pop_front(); c = q_cyc.pop_front();
          if (data_out !== sort_ref(d, m, 0)) begin bad++; $display("FAIL stream_data got=%h exp=%h", data_out, sort_ref(d, m, 0)); end
          total++; if (out_mode !== m) begin bad++; $display("FAIL stream_mode got=%b exp=%b", out_mode, m); end
          total++; if (cyc - c != 6) begin bad++; $display("FAIL stream_latency got=%0d exp=6", cyc - c); end
          total++; if (out_valid_s !== 1'b1 || data_out_s !== sort_ref(d, m, 1)) begin
            bad++; $display("FAIL stream_signed got=%h exp=%h", data_out_s, sort_ref(d, m, 1));
          end
        end
        got++;
      end else if (got > 0) begin
        total++; bad++; $display("FAIL stream_gap got=0 exp=1 after %0d outputs", got);
      end
      out_ready = 1'b1;
      if (sent < 20) begin
        in_valid = 1'b1; in_mode = sent[0]; data_in = {$urandom, $urandom};
        q_data.push_back(data_in); q_mode.push_back(in_mode); q_cyc.push_back(cyc + 1);
        sent++;
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    total++; if (got != 20) begin bad++; $display("FAIL stream_count got=%0d exp=20", got); end
  endtask

  task automatic test_backpressure;
    int sent = 0, got = 0, t = 0;
    logic [63:0] cur, prev_d, d;
    logic cur_m, prev_m, prev_stall, m;
    flush_q();
    prev_stall = 1'b0; prev_d = '0; prev_m = 1'b0;
    cur = {$urandom, $urandom}; cur_m = 1'($urandom_range(0, 1));
    while (got < 10 && t < 100) begin
      @(negedge clk); t++;
      out_ready = !(t >= 9 && t <= 11);
      in_valid = (sent < 10); in_mode = cur_m; data_in = cur;
      #1;
      total++; if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL bp_in_ready got=%b exp=%b t=%0d", in_ready, !(out_valid && !out_ready), t);
      end
      if (prev_stall) begin
        total++; if (data_out !== prev_d || out_mode !== prev_m) begin
          bad++; $display("FAIL bp_hold got=%h exp=%h", data_out, prev_d);
        end
      end
      prev_stall = out_valid && !out_ready; prev_d = data_out; prev_m = out_mode;
      if (out_valid && out_ready) begin
        total++;
        if (q_data.size() == 0) begin bad++; $display("FAIL bp_spurious got=%h exp=none", data_out); end
        else begin
          d = q_data.pop_front(); m = q_mode.pop_front(); void'(q_cyc.pop_front());
          if (data_out !== sort_ref(d, m, 0) || out_mode !== m) begin
            bad++; $display("FAIL bp_data got=%h/%b exp=%h/%b", data_out, out_mode, sort_ref(d, m, 0), m);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_data.push_back(cur); q_mode.push_back(cur_m); q_cyc.push_back(cyc + 1);
        sent++;
        cur = {$urandom, $urandom}; cur_m = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != 10 || q_data.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d left=%0d exp=10/0", got, q_data.size());
    end
  endtask

  task automatic test_reset_mid;
    int got = 0, c;
    logic [63:0] d;
    logic m;
    flush_q();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mode = 1'($urandom_range(0, 1)); data_in = {$urandom, $urandom}; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || data_out !== 64'h0) begin
      bad++; $display("FAIL rmid_async got=%b/%h exp=0/0", out_valid, data_out);
    end
    total++; if (out_mode !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_mode_ready got=%b/%b exp=0/1", out_mode, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale got=%b exp=0", out_valid); end
      in_valid = 1'b1; in_mode = 1'(i); data_in = {$urandom, $urandom};
      q_data.push_back(data_in); q_mode.push_back(in_mode); q_cyc.push_back(cyc + 1);
    end
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        total++;
        if (q_data.size() == 0) begin bad++; $display("FAIL rmid_spurious got=%h exp=none", data_out); end
        else begin
          d = q_data.pop_front(); m = q_mode.pop_front(); c = q_cyc.pop_front();
          if (data_out !== sort_ref(d, m, 0) || out_mode !== m) begin
            bad++; $display("FAIL rmid_data got=%h exp=%h", data_out, sort_ref(d, m, 0));
          end
          total++; if (cyc - c != 6) begin bad++; $display("FAIL rmid_latency got=%0d exp=6", cyc - c); end
        end
        got++;
      end
    end
    total++; if (got != 2) begin bad++; $display("FAIL rmid_count got=%0d exp=2", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
